// File: rtl/issue_scoreboard_pkg.sv
// Shared types and defaults for the issue scoreboard.
// Holds the slot record, the register-index width helper and parameter defaults.
package kl_issue_pkg;

  localparam int NLANES_D   = 2;
  localparam int NREGS_D    = 8;
  localparam int DW_D       = 16;
  localparam int NSRC_D     = 3;
  localparam int NSTAGES_D  = 3;
  localparam int LOAD_RDY_D = 2;

  // Widest register index a slot can hold.
  localparam int WN_MAX = 8;

  function automatic int rw_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic              valid;
    logic              write;
    logic              load;
    logic [WN_MAX-1:0] wnum;
  } slot_t;

endpackage

// File: rtl/issue_scoreboard_if.sv
// Issue-side bundle of the scoreboard: lane fields, operands, results.
// master drives the issue bundle, slave (scoreboard) returns accept/data/stall.
interface issue_scoreboard_if #(
  parameter int NLANES  = kl_issue_pkg::NLANES_D,
  parameter int NREGS   = kl_issue_pkg::NREGS_D,
  parameter int DW      = kl_issue_pkg::DW_D,
  parameter int NSRC    = kl_issue_pkg::NSRC_D,
  parameter int NSTAGES = kl_issue_pkg::NSTAGES_D
);
  import kl_issue_pkg::*;

  localparam int RW = rw_of(NREGS);

  logic [NLANES-1:0] iss_valid;
  logic [NLANES-1:0] iss_write;
  logic [NLANES-1:0] iss_load;
  logic [NLANES-1:0][RW-1:0] iss_wnum;
  logic [NLANES-1:0][NSRC-1:0][RW-1:0] iss_src;
  logic [NLANES-1:0][NSRC-1:0] iss_src_used;
  logic [NLANES-1:0][NSRC-1:0][DW-1:0] reg_data;
  logic [NSTAGES-1:0][NLANES-1:0][DW-1:0] stage_data;
  logic flush;

  logic [NLANES-1:0] iss_accept;
  logic [NLANES-1:0][NSRC-1:0][DW-1:0] src_data;
  logic stall;
  logic [15:0] stall_cnt;

  modport master (
    output iss_valid, iss_write, iss_load,
    output iss_wnum, iss_src, iss_src_used,
    output reg_data, stage_data, flush,
    input  iss_accept, src_data,
    input  stall, stall_cnt
  );

  modport slave (
    input  iss_valid, iss_write, iss_load,
    input  iss_wnum, iss_src, iss_src_used,
    input  reg_data, stage_data, flush,
    output iss_accept, src_data,
    output stall, stall_cnt
  );

endinterface

// File: rtl/issue_scoreboard_fwd_select.sv
// Priority match and operand mux for one source of one lane.
// Ports: src/used/reg_data in, slots/stage_data in, data/hazard out.
module fwd_select
  import kl_issue_pkg::*;
#(
  parameter int NLANES   = NLANES_D,
  parameter int NSTAGES  = NSTAGES_D,
  parameter int DW       = DW_D,
  parameter int RW       = 3,
  parameter int LOAD_RDY = LOAD_RDY_D
) (
  input  logic [RW-1:0] src,
  input  logic          used,
  input  logic [DW-1:0] reg_data,
  input  slot_t [NSTAGES-1:0][NLANES-1:0] slots,
  input  logic [NSTAGES-1:0][NLANES-1:0][DW-1:0] stage_data,
  output logic [DW-1:0] data,
  output logic          hazard
);

  // Walk from lowest to highest priority so the
  // youngest matching slot is the last one written.
  always_comb begin
    data   = reg_data;
    hazard = 1'b0;
    for (int k = NSTAGES - 1; k >= 0; k--) begin
      for (int l = 0; l < NLANES; l++) begin
        if (used &&
            slots[k][l].valid &&
            slots[k][l].write &&
            slots[k][l].wnum == WN_MAX'(src)) begin
          data = stage_data[k][l];
          if (slots[k][l].load && k < LOAD_RDY)
            hazard = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/issue_scoreboard.sv
// In-order multi-lane issue scoreboard with result forwarding.
// Ports: clk, rst (sync, active-low), bus (issue bundle, slave side).
module issue_scoreboard
  import kl_issue_pkg::*;
#(
  parameter int NLANES   = NLANES_D,
  parameter int NREGS    = NREGS_D,
  parameter int DW       = DW_D,
  parameter int NSRC     = NSRC_D,
  parameter int NSTAGES  = NSTAGES_D,
  parameter int LOAD_RDY = LOAD_RDY_D
) (
  input logic clk,
  input logic rst,
  issue_scoreboard_if.slave bus
);

  localparam int RW = rw_of(NREGS);

  slot_t [NSTAGES-1:0][NLANES-1:0] slots;

  logic [NLANES-1:0][NSRC-1:0] fwd_haz;
  logic [NLANES-1:0][NSRC-1:0][DW-1:0] fwd_data;
  logic [NLANES-1:0] intra;
  logic [NLANES-1:0] haz;
  logic [NLANES-1:0] accept;
  logic              stall;
  logic [15:0]       cnt;

  for (genvar l = 0; l < NLANES; l++) begin : g_lane
    for (genvar s = 0; s < NSRC; s++) begin : g_src
      fwd_select #(
        .NLANES   (NLANES),
        .NSTAGES  (NSTAGES),
        .DW       (DW),
        .RW       (RW),
        .LOAD_RDY (LOAD_RDY)
      ) u_fwd (
        .src        (bus.iss_src[l][s]),
        .used       (bus.iss_src_used[l][s]),
        .reg_data   (bus.reg_data[l][s]),
        .slots      (slots),
        .stage_data (bus.stage_data),
        .data       (fwd_data[l][s]),
        .hazard     (fwd_haz[l][s])
      );
    end
  end

  // Same-bundle RAW: results of older lanes are
  // not forwardable in their own issue cycle.
  always_comb begin
    intra = '0;
    for (int l = 0; l < NLANES; l++) begin
      for (int s = 0; s < NSRC; s++) begin
        for (int j = 0; j < l; j++) begin
          if (bus.iss_valid[j] &&
              bus.iss_write[j] &&
              bus.iss_src_used[l][s] &&
              bus.iss_src[l][s] == bus.iss_wnum[j])
            intra[l] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int l = 0; l < NLANES; l++)
      haz[l] = intra[l] | (|fwd_haz[l]);
  end

  // In-order prefix: a blocked valid lane closes
  // the gate; empty lanes pass it through.
  always_comb begin
    logic pass_ok;
    accept  = '0;
    pass_ok = rst & ~bus.flush;
    for (int l = 0; l < NLANES; l++) begin
      accept[l] = pass_ok & bus.iss_valid[l] & ~haz[l];
      if (bus.iss_valid[l] && !accept[l])
        pass_ok = 1'b0;
    end
  end

  assign stall = rst & ~bus.flush &
                 (|(bus.iss_valid & ~accept));

  always_ff @(posedge clk) begin
    if (!rst) begin
      slots <= '0;
      cnt   <= '0;
    end else begin
      for (int l = 0; l < NLANES; l++) begin
        slots[0][l].valid <= accept[l];
        slots[0][l].write <= bus.iss_write[l];
        slots[0][l].load  <= bus.iss_load[l];
        slots[0][l].wnum  <= WN_MAX'(bus.iss_wnum[l]);
      end
      for (int k = 1; k < NSTAGES; k++) begin
        for (int l = 0; l < NLANES; l++) begin
          slots[k][l]       <= slots[k-1][l];
          slots[k][l].valid <= slots[k-1][l].valid & ~bus.flush;
        end
      end
      if (stall && cnt != 16'hFFFF)
        cnt <= cnt + 16'd1;
    end
  end

  assign bus.iss_accept = accept;
  assign bus.src_data   = fwd_data;
  assign bus.stall      = stall;
  assign bus.stall_cnt  = cnt;

endmodule
